// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and packed-field helper for the Huffman sequencer.
package huffman_pkg;

   localparam int NSYM      = 10;
   localparam int FW        = 6;
   localparam int TW        = 15;
   localparam int MW        = 5;
   localparam int CW        = 13;
   localparam int START_CYC = 20;
   localparam int CODE_LAT  = 40;
   localparam int TIMEOUT   = 1023;
   localparam int TMR_W     = 10;

   localparam logic [3:0]       LAST_SYM     = 4'(NSYM - 1);
   localparam logic [TMR_W-1:0] START_LOAD   = 10'(START_CYC - 1);
   localparam logic [TMR_W-1:0] LAT_LOAD     = 10'(CODE_LAT - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD = 10'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_TREE,
      S_CODE,
      S_DRAIN
   } state_t;

   function automatic logic [CW-1:0] code_field(input logic [NSYM*CW-1:0] bus,
                                                input logic [3:0]         idx);
      return bus[int'(idx)*CW +: CW];
   endfunction

endpackage

// File: rtl/huffman_code_buf.sv
// Capture register for the ten code words with an indexed read port.
module huffman_code_buf
   import huffman_pkg::*;
(
   input  logic                 clk_sys,
   input  logic                 rst,
   input  logic                 capture,
   input  logic [NSYM*CW-1:0]   code_in,
   input  logic [3:0]           idx,
   output logic [CW-1:0]        code_out
);

   logic [NSYM*CW-1:0] code_r;

   always_ff @(posedge clk_sys) begin
      if (rst)
         code_r <= '0;
      else if (capture)
         code_r <= code_in;
   end

   assign code_out = code_field(code_r, idx);

endmodule

// File: rtl/huffman_seq.sv
// Sequencer: frequency load -> tree builder -> Huffman_code -> code drain.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for first frequency beat of a frame
//   S_LOAD  | collecting remaining frequency beats
//   S_TREE  | waiting for Tree_done (timeout -> Err), then one settle cycle
//   S_CODE  | Start_code phase, then fixed code latency phase
//   S_DRAIN | streaming Code0..Code9 one per handshake
module huffman_seq
   import huffman_pkg::*;
(
   input  logic                 Clk_in,
   input  logic                 Rst,
   input  logic [FW-1:0]        Freq_in,
   input  logic                 Freq_valid,
   output logic                 Freq_ready,
   output logic [NSYM*FW-1:0]   Freq_bus,
   output logic                 Tree_start,
   input  logic                 Tree_done,
   input  logic [8*TW-1:0]      Tree_in,
   input  logic [MW-1:0]        M1_in,
   input  logic [MW-1:0]        M2_in,
   output logic [8*TW-1:0]      Tree_out,
   output logic [MW-1:0]        M1_out,
   output logic [MW-1:0]        M2_out,
   output logic                 Start_code,
   input  logic [NSYM*CW-1:0]   Code_in,
   output logic [3:0]           Sym_out,
   output logic [CW-1:0]        Code_out,
   output logic                 Code_valid,
   input  logic                 Code_ready,
   output logic                 Busy,
   output logic                 Err
);

   state_t           state, state_next;
   logic [3:0]       cnt, idx;
   logic [TMR_W-1:0] tmr;
   logic             tree_got, lat_phase;
   logic             freq_hs, code_hs, tmr_tc, capture;

   assign Freq_ready = (state == S_IDLE) || (state == S_LOAD);
   assign Busy       = (state != S_IDLE);
   assign Code_valid = (state == S_DRAIN);
   assign Start_code = (state == S_CODE) && !lat_phase;
   assign Sym_out    = idx;
   assign freq_hs    = Freq_valid && Freq_ready;
   assign code_hs    = Code_valid && Code_ready;
   assign tmr_tc     = (tmr == '0);

   always_ff @(posedge Clk_in) begin
      if (Rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         S_IDLE:  if (freq_hs) state_next = S_LOAD;
         S_LOAD:  if (freq_hs && cnt == LAST_SYM) state_next = S_TREE;
         S_TREE: begin
            if (tree_got)
               state_next = S_CODE;
            else if (!Tree_done && tmr_tc)
               state_next = S_IDLE;
         end
         S_CODE: begin
            if (lat_phase && tmr_tc) begin
               state_next = S_DRAIN;
               capture    = 1'b1;
            end
         end
         S_DRAIN: if (code_hs && idx == LAST_SYM) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk_in) begin
      if (Rst) begin
         cnt        <= '0;
         idx        <= '0;
         tmr        <= '0;
         tree_got   <= 1'b0;
         lat_phase  <= 1'b0;
         Tree_start <= 1'b0;
         Err        <= 1'b0;
         Freq_bus   <= '0;
         Tree_out   <= '0;
         M1_out     <= '0;
         M2_out     <= '0;
      end else begin
         Tree_start <= 1'b0;
         if (freq_hs) begin
            Freq_bus[int'(cnt)*FW +: FW] <= Freq_in;
            if (cnt == '0)
               Err <= 1'b0;
            if (cnt == LAST_SYM) begin
               cnt        <= '0;
               Tree_start <= 1'b1;
               tmr        <= TIMEOUT_LOAD;
               tree_got   <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         case (state)
            S_TREE: begin
               // Result latched on Tree_done; the CODE entry happens one cycle later.
               if (tree_got) begin
                  tmr       <= START_LOAD;
                  lat_phase <= 1'b0;
               end else if (Tree_done) begin
                  Tree_out <= Tree_in;
                  M1_out   <= M1_in;
                  M2_out   <= M2_in;
                  tree_got <= 1'b1;
               end else if (tmr_tc) begin
                  Err <= 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_CODE: begin
               if (!tmr_tc) begin
                  tmr <= tmr - 1'b1;
               end else if (!lat_phase) begin
                  lat_phase <= 1'b1;
                  tmr       <= LAT_LOAD;
               end else begin
                  idx <= '0;
               end
            end
            S_DRAIN: begin
               if (code_hs)
                  idx <= (idx == LAST_SYM) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   huffman_code_buf u_code_buf (
      .clk_sys  (Clk_in),
      .rst      (Rst),
      .capture  (capture),
      .code_in  (Code_in),
      .idx      (idx),
      .code_out (Code_out)
   );

endmodule

// File: tb/tb_huffman_seq.sv
// Randomized bench for huffman_seq with a frame-level reference model.
module tb_huffman_seq;
   import huffman_pkg::*;

   logic                 Clk_in = 1'b0;
   logic                 Rst = 1'b1;
   logic [FW-1:0]        Freq_in = '0;
   logic                 Freq_valid = 1'b0;
   logic                 Freq_ready;
   logic [NSYM*FW-1:0]   Freq_bus;
   logic                 Tree_start;
   logic                 Tree_done = 1'b0;
   logic [8*TW-1:0]      Tree_in = '0;
   logic [MW-1:0]        M1_in = '0;
   logic [MW-1:0]        M2_in = '0;
   logic [8*TW-1:0]      Tree_out;
   logic [MW-1:0]        M1_out;
   logic [MW-1:0]        M2_out;
   logic                 Start_code;
   logic [NSYM*CW-1:0]   Code_in = '0;
   logic [3:0]           Sym_out;
   logic [CW-1:0]        Code_out;
   logic                 Code_valid;
   logic                 Code_ready = 1'b0;
   logic                 Busy;
   logic                 Err;

   huffman_seq dut (
      .Clk_in(Clk_in), .Rst(Rst), .Freq_in(Freq_in), .Freq_valid(Freq_valid),
      .Freq_ready(Freq_ready), .Freq_bus(Freq_bus), .Tree_start(Tree_start),
      .Tree_done(Tree_done), .Tree_in(Tree_in), .M1_in(M1_in), .M2_in(M2_in),
      .Tree_out(Tree_out), .M1_out(M1_out), .M2_out(M2_out), .Start_code(Start_code),
      .Code_in(Code_in), .Sym_out(Sym_out), .Code_out(Code_out), .Code_valid(Code_valid),
      .Code_ready(Code_ready), .Busy(Busy), .Err(Err)
   );

   always #5 Clk_in = ~Clk_in;

   int checks = 0;
   int errors = 0;
   int cyc = 0, ts_cnt = 0, sc_cnt = 0, hs_cnt = 0;

   always @(posedge Clk_in) begin
      cyc++;
      if (Tree_start) ts_cnt++;
      if (Start_code) sc_cnt++;
      if (Code_valid && Code_ready) hs_cnt++;
   end

   logic [FW-1:0]   f_frame [NSYM];
   logic [TW-1:0]   t_frame [8];
   logic [CW-1:0]   c_frame [NSYM];
   logic [MW-1:0]   m1_f, m2_f;
   logic [8*TW-1:0] prev_tree = '0;

   task automatic tick();
      @(negedge Clk_in);
   endtask

   function automatic logic [NSYM*CW-1:0] junk_codes();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[NSYM*CW-1:0];
   endfunction

   function automatic logic [8*TW-1:0] junk_tree();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[8*TW-1:0];
   endfunction

   task automatic set_nominal();
      f_frame = '{6'd53, 6'd40, 6'd26, 6'd14, 6'd38, 6'd23, 6'd7, 6'd12, 6'd4, 6'd39};
      t_frame = '{15'h28c8, 15'h2cea, 15'h30a3, 15'h344b, 15'h388c, 15'h3c29, 15'h400d, 15'h45ee};
      m1_f = 5'd16;
      m2_f = 5'd17;
      for (int k = 0; k < NSYM; k++) c_frame[k] = CW'($urandom());
   endtask

   task automatic set_random();
      for (int k = 0; k < NSYM; k++) f_frame[k] = FW'($urandom());
      f_frame[$urandom_range(0, NSYM-1)] = '0;
      for (int k = 0; k < 8; k++) t_frame[k] = TW'($urandom());
      m1_f = MW'($urandom());
      m2_f = MW'($urandom());
      for (int k = 0; k < NSYM; k++) c_frame[k] = CW'($urandom());
   endtask

   // One complete frame; tree_delay < 0 means the tree builder never answers,
   // reset_at > 0 asserts Rst during that Start_code cycle.
   task automatic run_frame(input bit gapped, input int bp_idx, input int tree_delay, input int reset_at);
      logic [NSYM*FW-1:0] exp_freq;
      logic [8*TW-1:0]    exp_tree;
      logic [NSYM*CW-1:0] exp_codes;
      int ts0, hs0, sc0, n, low, sc_hi, t_done, hold;
      bit got;

      exp_freq = '0;
      for (int k = 0; k < NSYM; k++) exp_freq[k*FW +: FW] = f_frame[k];
      exp_tree = '0;
      for (int k = 0; k < 8; k++) exp_tree[k*TW +: TW] = t_frame[k];
      exp_codes = '0;
      for (int k = 0; k < NSYM; k++) exp_codes[k*CW +: CW] = c_frame[k];
      ts0 = ts_cnt;
      hs0 = hs_cnt;

      for (int k = 0; k < NSYM; k++) begin
         if (gapped && (k % 2 == 1)) begin
            Freq_valid = 1'b0;
            Freq_in = FW'($urandom());
            if (k == 5) begin
               Tree_done = 1'b1;
               Tree_in = junk_tree();
            end
            tick();
            Tree_done = 1'b0;
            checks++;
            if (Freq_ready !== 1'b1 || Start_code !== 1'b0 || Tree_out !== prev_tree) begin
               errors++;
               $display("FAIL gap_ignore k=%0d got ready=%b start_code=%b tree=%h exp ready=1 start_code=0 tree=%h",
                        k, Freq_ready, Start_code, Tree_out, prev_tree);
            end
         end
         checks++;
         if (Freq_ready !== 1'b1) begin
            errors++;
            $display("FAIL freq_ready k=%0d got %b exp 1", k, Freq_ready);
         end
         Freq_valid = 1'b1;
         Freq_in = f_frame[k];
         tick();
         if (k == 0) begin
            checks++;
            if (Err !== 1'b0) begin
               errors++;
               $display("FAIL err_clear got %b exp 0", Err);
            end
         end
      end
      Freq_valid = 1'b0;
      checks++;
      if (Tree_start !== 1'b1 || Freq_ready !== 1'b0 || Freq_bus !== exp_freq) begin
         errors++;
         $display("FAIL load_done got tree_start=%b ready=%b bus=%h exp tree_start=1 ready=0 bus=%h",
                  Tree_start, Freq_ready, Freq_bus, exp_freq);
      end

      if (tree_delay < 0) begin
         sc0 = sc_cnt;
         n = 0;
         while (Err !== 1'b1 && n < TIMEOUT + 100) begin
            tick();
            n++;
         end
         checks++;
         if (n != TIMEOUT || Err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycle got %0d err=%b exp %0d err=1", n, Err, TIMEOUT);
         end
         checks++;
         if (Busy !== 1'b0 || Freq_ready !== 1'b1 || Tree_out !== prev_tree) begin
            errors++;
            $display("FAIL timeout_idle got busy=%b ready=%b tree=%h exp busy=0 ready=1 tree=%h",
                     Busy, Freq_ready, Tree_out, prev_tree);
         end
         repeat (3) tick();
         checks++;
         if (sc_cnt != sc0 || Err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_no_code got start_code_cycles=%0d err=%b exp 0 err=1", sc_cnt - sc0, Err);
         end
         return;
      end

      hold = gapped ? 3 : 1;
      repeat (tree_delay) tick();
      Tree_done = 1'b1;
      Tree_in = exp_tree;
      M1_in = m1_f;
      M2_in = m2_f;
      t_done = cyc;
      tick();
      sc_hi = 0;
      low = 0;
      got = 0;
      while (cyc - t_done < 200) begin
         if (cyc - t_done == hold) begin
            Tree_done = 1'b0;
            Tree_in = junk_tree();
            M1_in = MW'($urandom());
            M2_in = MW'($urandom());
         end
         if (cyc - t_done == 1) begin
            checks++;
            if (Tree_out !== exp_tree || M1_out !== m1_f || M2_out !== m2_f) begin
               errors++;
               $display("FAIL tree_latch got %h m1=%0d m2=%0d exp %h m1=%0d m2=%0d",
                        Tree_out, M1_out, M2_out, exp_tree, m1_f, m2_f);
            end
         end
         if (Code_valid === 1'b1) begin
            got = 1;
            break;
         end
         if (Start_code === 1'b1) begin
            sc_hi++;
            Code_in = junk_codes();
            if (reset_at > 0 && sc_hi == reset_at) begin
               Rst = 1'b1;
               tick();
               checks++;
               if (Start_code !== 1'b0 || Busy !== 1'b0 || Freq_ready !== 1'b1 || Code_valid !== 1'b0 ||
                   Tree_out !== '0 || Err !== 1'b0) begin
                  errors++;
                  $display("FAIL reset_mid got start_code=%b busy=%b ready=%b valid=%b tree=%h err=%b exp 0 0 1 0 0 0",
                           Start_code, Busy, Freq_ready, Code_valid, Tree_out, Err);
               end
               Rst = 1'b0;
               prev_tree = '0;
               tick();
               return;
            end
         end else if (sc_hi > 0) begin
            low++;
            Code_in = (low == CODE_LAT) ? exp_codes : junk_codes();
         end else begin
            Code_in = junk_codes();
         end
         tick();
      end
      Code_in = junk_codes();
      checks++;
      if (!got || (cyc - t_done) != START_CYC + CODE_LAT + 2) begin
         errors++;
         $display("FAIL code_latency got %0d valid_seen=%0d exp %0d", cyc - t_done, got, START_CYC + CODE_LAT + 2);
      end
      checks++;
      if (sc_hi != START_CYC) begin
         errors++;
         $display("FAIL start_code_len got %0d exp %0d", sc_hi, START_CYC);
      end
      if (!got) begin
         Rst = 1'b1;
         tick();
         Rst = 1'b0;
         prev_tree = '0;
         tick();
         return;
      end

      for (int k = 0; k < NSYM; k++) begin
         if (k == bp_idx) begin
            Code_ready = 1'b0;
            repeat (7) begin
               checks++;
               if (Code_valid !== 1'b1 || Sym_out !== 4'(k) || Code_out !== c_frame[k]) begin
                  errors++;
                  $display("FAIL backpressure_hold got valid=%b sym=%0d code=%h exp valid=1 sym=%0d code=%h",
                           Code_valid, Sym_out, Code_out, k, c_frame[k]);
               end
               tick();
            end
         end else if ($urandom_range(0, 3) == 0) begin
            Code_ready = 1'b0;
            tick();
         end
         Code_ready = 1'b1;
         checks++;
         if (Code_valid !== 1'b1 || Sym_out !== 4'(k) || Code_out !== c_frame[k]) begin
            errors++;
            $display("FAIL code_word got valid=%b sym=%0d code=%h exp valid=1 sym=%0d code=%h",
                     Code_valid, Sym_out, Code_out, k, c_frame[k]);
         end
         tick();
      end
      checks++;
      if (Code_valid !== 1'b0 || Busy !== 1'b0 || Freq_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_end got valid=%b busy=%b ready=%b exp 0 0 1", Code_valid, Busy, Freq_ready);
      end
      repeat (2) tick();
      Code_ready = 1'b0;
      checks++;
      if (hs_cnt - hs0 != NSYM || ts_cnt - ts0 != 1 || Tree_out !== exp_tree) begin
         errors++;
         $display("FAIL frame_counts got handshakes=%0d tree_starts=%0d tree=%h exp %0d 1 %h",
                  hs_cnt - hs0, ts_cnt - ts0, Tree_out, NSYM, exp_tree);
      end
      prev_tree = exp_tree;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (Freq_ready !== 1'b1 || Busy !== 1'b0 || Tree_start !== 1'b0 || Start_code !== 1'b0 ||
          Code_valid !== 1'b0 || Err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got ready=%b busy=%b ts=%b sc=%b valid=%b err=%b exp 1 0 0 0 0 0",
                  Freq_ready, Busy, Tree_start, Start_code, Code_valid, Err);
      end
      checks++;
      if (Freq_bus !== '0 || Tree_out !== '0 || M1_out !== '0 || M2_out !== '0 ||
          Sym_out !== '0 || Code_out !== '0) begin
         errors++;
         $display("FAIL reset_data got bus=%h tree=%h m1=%0d m2=%0d sym=%0d code=%h exp all 0",
                  Freq_bus, Tree_out, M1_out, M2_out, Sym_out, Code_out);
      end
      Rst = 1'b0;
      tick();
   endtask

   task automatic test_nominal();
      set_nominal();
      run_frame(1'b0, -1, 3, 0);
   endtask

   task automatic test_backpressure();
      set_random();
      run_frame(1'b0, 3, 5, 0);
   endtask

   task automatic test_timeout();
      set_random();
      run_frame(1'b0, -1, -1, 0);
      set_random();
      run_frame(1'b0, -1, 2, 0);
      checks++;
      if (Err !== 1'b0) begin
         errors++;
         $display("FAIL err_after_recovery got %b exp 0", Err);
      end
   endtask

   task automatic test_reset_mid_code();
      set_random();
      run_frame(1'b0, -1, 1, 10);
      set_random();
      run_frame(1'b0, -1, 0, 0);
   endtask

   task automatic test_gapped();
      set_random();
      run_frame(1'b1, -1, 4, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         set_random();
         run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, NSYM-1)), int'($urandom_range(0, 6)), 0);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_timeout();
      test_reset_mid_code();
      test_gapped();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no completion exp finish");
      $fatal(1, "watchdog");
   end

endmodule
